// File: rtl/if_stage_pkg.sv
// Shared widths and constants for the instruction-fetch stage and its
// neighbours on the IF->ID interface.
package if_stage_pkg;

  // {fs_inst[63:32], fs_pc[31:0]}
  localparam int FS_TO_DS_BUS_WD = 64;

  // {br_taken[32], br_target[31:0]}
  localparam int BR_BUS_WD = 33;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  // Sequential successor of a pc; wraps naturally at 32 bits.
  function automatic logic [31:0] seqPcOf(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: pre-IF nextpc generation, the IF pc/valid
// register, and a one-entry buffer that keeps the SRAM read data alive
// while decode stalls (the SRAM only guarantees it for one cycle).
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       ds_allowin,
  input  logic [BR_BUS_WD-1:0]       br_bus,
  output logic                       fs_to_ds_valid,
  output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
  output logic                       inst_sram_en,
  output logic [3:0]                 inst_sram_we,
  output logic [31:0]                inst_sram_addr,
  output logic [31:0]                inst_sram_wdata,
  input  logic [31:0]                inst_sram_rdata
);

  logic        brTaken;
  logic [31:0] brTarget;

  logic        toFsValid_q, toFsValid_d;
  logic        fsValid_q,   fsValid_d;
  logic [31:0] fsPc_q,      fsPc_d;
  logic        fsFirst_q,   fsFirst_d;
  logic        bufValid_q,  bufValid_d;
  logic [31:0] instBuf_q,   instBuf_d;

  logic        toFsValid;
  logic [31:0] seqPc;
  logic [31:0] nextPc;
  logic        fsReadyGo;
  logic        fsAllowin;
  logic [31:0] fsInst;

  assign brTaken  = br_bus[32];
  assign brTarget = br_bus[31:0];

  // Pre-IF: choose the next fetch address. A taken branch overrides the
  // sequential pc; the instruction currently in IF is then wrong-path.
  always_comb begin
    toFsValid = toFsValid_q;
    seqPc     = seqPcOf(fsPc_q);
    nextPc    = brTaken ? brTarget : seqPc;
  end

  // IF handshake and SRAM request. Requests are only issued when IF can
  // accept the returning instruction, so a stalled IF issues nothing.
  always_comb begin
    fsReadyGo      = 1'b1;
    fsAllowin      = !fsValid_q || (fsReadyGo && ds_allowin);
    fs_to_ds_valid = fsValid_q && fsReadyGo && !brTaken;
    inst_sram_en   = toFsValid && fsAllowin;
    inst_sram_addr = nextPc;
    inst_sram_we   = 4'b0000;
    inst_sram_wdata = 32'h0000_0000;
    fsInst         = bufValid_q ? instBuf_q : inst_sram_rdata;
    fs_to_ds_bus   = {fsInst, fsPc_q};
  end

  // Next-state logic. When IF advances, the buffer is dropped and fsFirst
  // marks that the SRAM data for the new pc arrives next cycle. When IF
  // stalls, the fresh SRAM data is captured once before it disappears.
  always_comb begin
    toFsValid_d = 1'b1;
    fsValid_d   = fsValid_q;
    fsPc_d      = fsPc_q;
    fsFirst_d   = 1'b0;
    bufValid_d  = bufValid_q;
    instBuf_d   = instBuf_q;
    if (fsAllowin) begin
      fsValid_d  = toFsValid;
      if (toFsValid) begin
        fsPc_d = nextPc;
      end
      fsFirst_d  = inst_sram_en;
      bufValid_d = 1'b0;
    end else if (fsValid_q && fsFirst_q && !bufValid_q) begin
      bufValid_d = 1'b1;
      instBuf_d  = inst_sram_rdata;
    end
  end

  // State registers with synchronous active-low reset; a reset discards
  // any in-flight fetch and buffered instruction.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      toFsValid_q <= 1'b0;
      fsValid_q   <= 1'b0;
      fsPc_q      <= RESET_PC - 32'd4;
      fsFirst_q   <= 1'b0;
      bufValid_q  <= 1'b0;
      instBuf_q   <= 32'h0000_0000;
    end else begin
      toFsValid_q <= toFsValid_d;
      fsValid_q   <= fsValid_d;
      fsPc_q      <= fsPc_d;
      fsFirst_q   <= fsFirst_d;
      bufValid_q  <= bufValid_d;
      instBuf_q   <= instBuf_d;
    end
  end

endmodule
